i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DW, default 32, sample width in bits; legal range 16..32.
REQ-002 Parameter TYPE, default "I2S", serial format; legal values "I2S", "LJUST", "RJUST".
REQ-003 bclk  input  1  bit clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  stereo sample pair offered.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 in_l  input  DW  left sample.
REQ-008 in_r  input  DW  right sample.
REQ-009 lrck  output  1  word clock; 0 = left slot, 1 = right slot.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 underrun  output  1  one-cycle pulse: frame started with no new pair available.

Function
REQ-012 The block SHALL act as frame master: a 6-bit counter cnt SHALL increment every bclk and wrap 63->0, giving 64 bclk per frame and 32 per slot.
REQ-013 The block SHALL register lrck = cnt[5], so lrck is low for cnt 0..31 and high for cnt 32..63.
REQ-014 The block SHALL register sdata; slot position p = cnt[4:0]; sample bits are indexed DW-1 (MSB) .. 0 (LSB).
REQ-015 For TYPE "LJUST", p = 0..DW-1 SHALL carry bit DW-1-p; remaining positions SHALL carry 0.
REQ-016 For TYPE "I2S", p = 1..DW SHALL carry bit DW-p; remaining positions SHALL carry 0.
REQ-017 For TYPE "I2S" with DW=32, the LSB SHALL be output at p = 0 of the following slot; the right LSB SHALL fall at p = 0 of the next frame's left slot.
REQ-018 For TYPE "RJUST", p = 32-DW..31 SHALL carry bit 31-p; leading positions SHALL carry 0.
REQ-019 The block SHALL contain a one-pair holding register, hold, with a full flag, plus an active register pair that is serialized.
REQ-020 in_ready SHALL equal !hold_full; a transfer occurs when in_valid && in_ready, and the pair SHALL be written into hold.
REQ-021 At the edge where cnt wraps 63->0, if hold is full, the active pair SHALL load from hold and hold_full SHALL clear.
REQ-022 If a transfer and a wrap load occur in the same cycle, they cannot conflict, since in_ready=0 whenever hold is full.
REQ-023 A transfer in the wrap cycle with hold empty SHALL NOT be loaded until the next wrap; latency is one frame minimum.
REQ-024 At the wrap edge, if hold is empty, underrun SHALL pulse high for exactly one cycle, and the active pair SHALL be handled as set by REQ-030.
REQ-025 While hold is full, in_valid SHALL be ignored and in_l/in_r SHALL NOT be sampled.
REQ-026 A pair loaded at a wrap SHALL occupy exactly one frame: left slot, then right slot.

Reset
REQ-027 On rst assertion, the block SHALL immediately set: cnt=0, lrck=0, sdata=0, underrun=0, hold_full=0, hold=0, active=0.
REQ-028 in_ready SHALL read 1 from the first cycle after rst deasserts.
REQ-029 Reset mid-frame SHALL abandon the current frame; the first frame after release SHALL transmit zeros and SHALL pulse underrun at the first wrap if no pair has been accepted by then.

Configuration
REQ-030 Macro I2S_TX_UNDERRUN_REPEAT_EN: if defined, on underrun the active pair SHALL be retained and retransmitted; if not defined, the active pair SHALL be cleared to zero on underrun. underrun SHALL pulse in both builds.

Verification
REQ-031 DW=32, TYPE "LJUST": push L=0x80000001, R=0x7FFFFFFF before the first wrap; the next frame SHALL show sdata=1 at cnt 0 and 31, and sdata=0 at cnt 32 followed by 31 ones; lrck SHALL rise at cnt 32.
REQ-032 DW=24, TYPE "I2S": L=0xABCDEF; sdata at p=1..24 SHALL be the bits of 0xABCDEF MSB-first, with p=0 and p=25..31 equal to 0.
REQ-033 DW=16, TYPE "RJUST": R=0x8001; sdata SHALL be 0 at p=0..15, 1 at p=16, 0 at p=17..30, and 1 at p=31 of the right slot.
REQ-034 Backpressure: hold in_valid=1 continuously; in_ready SHALL drop after the accept, rise the cycle after each wrap, and exactly one pair per frame SHALL be accepted.
REQ-035 Starvation: after one pair, drive in_valid=0; underrun SHALL pulse at the next wrap; the next frame SHALL be all zeros without the macro and SHALL repeat the pair with I2S_TX_UNDERRUN_REPEAT_EN.
REQ-036 Assert rst at cnt=40; lrck, sdata and in_ready SHALL go to 0 asynchronously, and after release cnt SHALL restart at 0 with in_ready=1.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S / left-justified / right-justified serial transmitter, frame master (64 bclk per frame).
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun, retransmit the last pair instead of zeros.
module i2s_tx #(
  parameter int    DW   = 32,
  parameter string TYPE = "I2S"
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  output logic          lrck,
  output logic          sdata,
  output logic          underrun
);

  localparam bit         IS_LJ = (TYPE == "LJUST");
  localparam bit         IS_RJ = (TYPE == "RJUST");
  localparam logic [5:0] DW6   = 6'(DW);

  logic [5:0]    cnt, cnt_next;
  logic [DW-1:0] hold_l, hold_r, hold_l_n, hold_r_n;
  logic [DW-1:0] act_l, act_r, act_l_n, act_r_n;
  logic          hold_full, hold_full_n;
  logic          under_n, sdata_n, wrap, take, prev_lsb;
  logic [DW-1:0] word;

  // Bit carried at slot position pos; prev is the LSB of the preceding slot (I2S, DW=32 only).
  function automatic logic pick(input logic [DW-1:0] w, input logic prev, input logic [4:0] pos);
    logic [31:0] wx;
    logic [5:0]  pe;
    logic [4:0]  idx;
    logic        r;
    wx  = 32'(w);
    pe  = {1'b0, pos};
    r   = 1'b0;
    idx = '0;
    if (IS_LJ) begin
      if (pe < DW6) begin
        idx = 5'(DW6 - 6'd1 - pe);
        r   = wx[idx];
      end
    end else if (IS_RJ) begin
      if (pe + DW6 >= 6'd32) begin
        idx = 5'(6'd31 - pe);
        r   = wx[idx];
      end
    end else begin
      if (pe == '0) begin
        r = (DW == 32) ? prev : 1'b0;
      end else if (pe <= DW6) begin
        idx = 5'(DW6 - pe);
        r   = wx[idx];
      end
    end
    return r;
  endfunction

  assign in_ready = !hold_full && !rst;

  always_comb begin
    cnt_next    = cnt + 6'd1;
    wrap        = (cnt == '1);
    take        = in_valid && in_ready;
    hold_l_n    = hold_l;
    hold_r_n    = hold_r;
    hold_full_n = hold_full;
    act_l_n     = act_l;
    act_r_n     = act_r;
    under_n     = 1'b0;

    if (take) begin
      hold_l_n    = in_l;
      hold_r_n    = in_r;
      hold_full_n = 1'b1;
    end

    if (wrap) begin
      if (hold_full) begin
        act_l_n     = hold_l;
        act_r_n     = hold_r;
        hold_full_n = 1'b0;
      end else begin
        under_n = 1'b1;
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
        act_l_n = '0;
        act_r_n = '0;
`endif
      end
    end

    // Outputs are registered against the upcoming count, so they line up with cnt after the edge.
    word     = cnt_next[5] ? act_r_n : act_l_n;
    prev_lsb = cnt_next[5] ? act_l[0] : act_r[0];
    sdata_n  = pick(word, prev_lsb, cnt_next[4:0]);
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
    end else begin
      cnt       <= cnt_next;
      lrck      <= cnt_next[5];
      sdata     <= sdata_n;
      underrun  <= under_n;
      hold_full <= hold_full_n;
      hold_l    <= hold_l_n;
      hold_r    <= hold_r_n;
      act_l     <= act_l_n;
      act_r     <= act_r_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: four format/width instances against a frame-level reference model.
module tb_i2s_tx;

  logic        bclk = 1'b0;
  logic        rst  = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_l = '0, in_r = '0;
  logic [3:0]  rdy, lr, sd, und;

  i2s_tx #(.DW(32), .TYPE("LJUST")) u_lj32 (.bclk(bclk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy[0]), .in_l(in_l), .in_r(in_r), .lrck(lr[0]), .sdata(sd[0]), .underrun(und[0]));
  i2s_tx #(.DW(24), .TYPE("I2S")) u_i2s24 (.bclk(bclk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy[1]), .in_l(in_l[23:0]), .in_r(in_r[23:0]), .lrck(lr[1]), .sdata(sd[1]), .underrun(und[1]));
  i2s_tx #(.DW(16), .TYPE("RJUST")) u_rj16 (.bclk(bclk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy[2]), .in_l(in_l[15:0]), .in_r(in_r[15:0]), .lrck(lr[2]), .sdata(sd[2]), .underrun(und[2]));
  i2s_tx #(.DW(32), .TYPE("I2S")) u_i2s32 (.bclk(bclk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy[3]), .in_l(in_l), .in_r(in_r), .lrck(lr[3]), .sdata(sd[3]), .underrun(und[3]));

  always #5 bclk = ~bclk;

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one-deep hold queue, pair per frame, serial stream built from whole-frame vectors.
  int          mcnt;
  logic        m_full, exp_under;
  logic [31:0] m_hl, m_hr, cur_l, cur_r, prev_r;

  always @(posedge bclk or posedge rst) begin
    if (rst) begin
      mcnt <= 0; m_full <= 1'b0; m_hl <= '0; m_hr <= '0;
      cur_l <= '0; cur_r <= '0; prev_r <= '0; exp_under <= 1'b0;
    end else begin
      exp_under <= 1'b0;
      if (mcnt == 63) begin
        prev_r <= cur_r;
        if (m_full) begin
          cur_l <= m_hl; cur_r <= m_hr; m_full <= 1'b0;
        end else begin
          exp_under <= 1'b1;
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
          cur_l <= '0; cur_r <= '0;
`endif
        end
      end
      if (in_valid && !m_full) begin
        m_hl <= in_l; m_hr <= in_r; m_full <= 1'b1;
      end
      mcnt <= (mcnt + 1) % 64;
    end
  end

  function automatic int dw_of(input int i);
    return (i == 1) ? 24 : (i == 2) ? 16 : 32;
  endfunction

  // Left-justified frame is the slots MSB-aligned; right-justified is LSB-aligned; I2S is LJ delayed one bclk.
  function automatic logic expbit(input int i, input logic [31:0] l, input logic [31:0] r,
                                  input logic [31:0] pr, input int c);
    logic [31:0] m, ljp;
    logic [63:0] f;
    int dw;
    dw = dw_of(i);
    m  = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    if (i == 2) f = {l & m, r & m};
    else        f = {(l & m) << (32 - dw), (r & m) << (32 - dw)};
    if (i == 1 || i == 3) begin
      ljp = (pr & m) << (32 - dw);
      return (c == 0) ? ljp[0] : f[64 - c];
    end
    return f[63 - c];
  endfunction

  always @(negedge bclk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sdata[%0d] cnt%0d", i, mcnt), 32'(sd[i]), 32'(expbit(i, cur_l, cur_r, prev_r, mcnt)));
        check($sformatf("lrck[%0d] cnt%0d", i, mcnt), 32'(lr[i]), 32'(mcnt >= 32));
        check($sformatf("in_ready[%0d] cnt%0d", i, mcnt), 32'(rdy[i]), 32'(!m_full && !rst));
        check($sformatf("underrun[%0d] cnt%0d", i, mcnt), 32'(und[i]), 32'(exp_under));
      end
    end
  end

  task automatic step();
    @(negedge bclk);
    #1;
  endtask

  task automatic wait_cnt(input int target);
    for (int k = 0; k < 200 && mcnt != target; k++) step();
    check($sformatf("reach cnt %0d", target), 32'(mcnt), 32'(target));
  endtask

  typedef struct {
    int    fr;
    int    ch;   // 0..3 sdata of each instance, 4 = lrck
    int    c;
    bit    exp;
    string name;
  } vec_t;

  vec_t tbl[$];
  bit   cap[2][5][64];

  localparam logic [31:0] A_L = 32'h80AB_CDEF, A_R = 32'h7FFF_FFFF;
  localparam logic [31:0] B_L = 32'h1234_5678, B_R = 32'h0000_8001;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int ones, acc, cycles;
    tbl.push_back('{0, 0, 0, 1'b1, "lj32 A c0"});   tbl.push_back('{0, 0, 1, 1'b0, "lj32 A c1"});
    tbl.push_back('{0, 0, 31, 1'b1, "lj32 A c31"}); tbl.push_back('{0, 0, 32, 1'b0, "lj32 A c32"});
    tbl.push_back('{0, 0, 33, 1'b1, "lj32 A c33"}); tbl.push_back('{0, 0, 63, 1'b1, "lj32 A c63"});
    tbl.push_back('{1, 0, 0, 1'b0, "lj32 B c0"});   tbl.push_back('{1, 0, 3, 1'b1, "lj32 B c3"});
    tbl.push_back('{0, 4, 0, 1'b0, "lrck c0"});     tbl.push_back('{0, 4, 31, 1'b0, "lrck c31"});
    tbl.push_back('{0, 4, 32, 1'b1, "lrck c32"});   tbl.push_back('{0, 4, 63, 1'b1, "lrck c63"});
    tbl.push_back('{0, 1, 0, 1'b0, "i2s24 A c0"});  tbl.push_back('{0, 1, 1, 1'b1, "i2s24 A c1"});
    tbl.push_back('{0, 1, 2, 1'b0, "i2s24 A c2"});  tbl.push_back('{0, 1, 6, 1'b0, "i2s24 A c6"});
    tbl.push_back('{0, 1, 8, 1'b1, "i2s24 A c8"});  tbl.push_back('{0, 1, 24, 1'b1, "i2s24 A c24"});
    tbl.push_back('{0, 1, 25, 1'b0, "i2s24 A c25"}); tbl.push_back('{0, 1, 31, 1'b0, "i2s24 A c31"});
    tbl.push_back('{0, 1, 32, 1'b0, "i2s24 A c32"}); tbl.push_back('{0, 1, 33, 1'b1, "i2s24 A c33"});
    tbl.push_back('{0, 1, 56, 1'b1, "i2s24 A c56"}); tbl.push_back('{0, 1, 57, 1'b0, "i2s24 A c57"});
    tbl.push_back('{1, 2, 15, 1'b0, "rj16 B c15"});  tbl.push_back('{1, 2, 17, 1'b1, "rj16 B c17"});
    tbl.push_back('{1, 2, 28, 1'b1, "rj16 B c28"});  tbl.push_back('{1, 2, 32, 1'b0, "rj16 B c32"});
    tbl.push_back('{1, 2, 47, 1'b0, "rj16 B c47"});  tbl.push_back('{1, 2, 48, 1'b1, "rj16 B c48"});
    tbl.push_back('{1, 2, 49, 1'b0, "rj16 B c49"});  tbl.push_back('{1, 2, 62, 1'b0, "rj16 B c62"});
    tbl.push_back('{1, 2, 63, 1'b1, "rj16 B c63"});
    tbl.push_back('{0, 3, 0, 1'b0, "i2s32 A c0"});  tbl.push_back('{0, 3, 1, 1'b1, "i2s32 A c1"});
    tbl.push_back('{0, 3, 32, 1'b1, "i2s32 A c32"}); tbl.push_back('{0, 3, 33, 1'b0, "i2s32 A c33"});
    tbl.push_back('{0, 3, 34, 1'b1, "i2s32 A c34"}); tbl.push_back('{1, 3, 0, 1'b1, "i2s32 B c0"});
    tbl.push_back('{1, 3, 1, 1'b0, "i2s32 B c1"});  tbl.push_back('{1, 3, 4, 1'b1, "i2s32 B c4"});

    // Reset state
    rst = 1'b1;
    #1 mon_en = 1'b1;
    repeat (3) step();
    check("reset lrck", 32'(lr), 0);
    check("reset sdata", 32'(sd), 0);
    check("reset underrun", 32'(und), 0);
    check("reset in_ready", 32'(rdy), 0);
    rst = 1'b0;
    #1 check("in_ready after release", 32'(rdy), 32'hF);

    // Directed frames A then B, then starvation
    in_l = A_L; in_r = A_R; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_cnt(0);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 64; c++) begin
        for (int i = 0; i < 4; i++) cap[f][i][c] = sd[i];
        cap[f][4][c] = lr[0];
        if (f == 0 && c == 0) begin
          in_l = B_L; in_r = B_R; in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        step();
      end
    end
    check("underrun on starve", 32'(und), 32'hF);
    ones = 0;
    for (int c = 0; c < 64; c++) begin
      ones += int'(sd[0]);
      step();
    end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    check("starved frame ones", 32'(ones), 15);
`else
    check("starved frame ones", 32'(ones), 0);
`endif
    foreach (tbl[k]) check(tbl[k].name, 32'(cap[tbl[k].fr][tbl[k].ch][tbl[k].c]), 32'(tbl[k].exp));

    // Backpressure: continuous valid admits exactly one pair per frame
    wait_cnt(50);
    in_valid = 1'b1;
    wait_cnt(1);
    acc = 0;
    for (int c = 0; c < 192; c++) begin
      if (in_valid && rdy[0]) acc++;
      in_l = $urandom; in_r = $urandom;
      step();
    end
    check("accepts in 3 frames", 32'(acc), 3);

    // Randomized traffic with occasional starved frames
    for (int fr = 0; fr < 20; fr++) begin
      bit starve;
      starve = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 64; c++) begin
        in_valid = !starve && ($urandom_range(0, 7) == 0);
        in_l = $urandom; in_r = $urandom;
        step();
      end
    end

    // Asynchronous reset mid-frame
    in_valid = 1'b0;
    wait_cnt(40);
    rst = 1'b1;
    #1;
    check("async rst lrck", 32'(lr), 0);
    check("async rst sdata", 32'(sd), 0);
    check("async rst in_ready", 32'(rdy), 0);
    step();
    step();
    rst = 1'b0;
    #1 check("in_ready after mid-frame reset", 32'(rdy), 32'hF);
    cycles = 0;
    for (int k = 0; k < 100 && lr[0] != 1'b1; k++) begin
      step();
      cycles++;
    end
    check("lrck rise after reset", 32'(cycles), 32);
    repeat (32) step();
    check("underrun at first wrap after reset", 32'(und), 32'hF);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
